// File: rtl/booth_r4_seq_mac.sv
// Sequential radix-4 Booth 8x8 signed multiplier with a 20-bit accumulator.
// Four Booth iterations per product; one multiply every six cycles.
module booth_r4_seq_mac (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        accumulate,
    input  logic        acc_clr,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [19:0] acc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_a;
    logic [8:0]  r_b;
    logic        r_accum;
    logic [1:0]  r_cnt;
    logic [15:0] r_psum;
    logic [15:0] r_product;
    logic [19:0] r_acc;

    logic        w_neg;
    logic        w_sel_a;
    logic        w_sel_2a;
    logic [9:0]  w_mag;
    logic [9:0]  w_pp;
    logic [15:0] w_pp_ext;
    logic [15:0] w_cin_ext;
    logic [15:0] w_addend;
    logic [15:0] w_psum_nxt;
    logic [19:0] w_acc_base;
    logic [19:0] w_prod_ext;

    // r_b holds {b, 1'b0} so the low three bits are always the current triplet
    always_comb begin
        w_neg    = 1'b0;
        w_sel_a  = 1'b0;
        w_sel_2a = 1'b0;
        case (r_b[2:0])
            3'b001, 3'b010: w_sel_a = 1'b1;
            3'b011:         w_sel_2a = 1'b1;
            3'b100: begin
                w_sel_2a = 1'b1;
                w_neg    = 1'b1;
            end
            3'b101, 3'b110: begin
                w_sel_a = 1'b1;
                w_neg   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_mag = '0;
        if (w_sel_2a) begin
            w_mag = {r_a[7], r_a, 1'b0};
        end else if (w_sel_a) begin
            w_mag = {{2{r_a[7]}}, r_a};
        end
        w_pp       = w_neg ? ~w_mag : w_mag;
        w_pp_ext   = {{6{w_pp[9]}}, w_pp};
        w_cin_ext  = {15'd0, w_neg};
        w_addend   = (w_pp_ext + w_cin_ext) << {r_cnt, 1'b0};
        w_psum_nxt = r_psum + w_addend;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_accum   <= 1'b0;
            r_cnt     <= '0;
            r_psum    <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= {b, 1'b0};
                        r_accum <= accumulate;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_psum <= w_psum_nxt;
                    r_b    <= {r_b[8], r_b[8], r_b[8:2]};
                    r_cnt  <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_product <= w_psum_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear takes effect before a same-edge accumulate: acc becomes the product
    assign w_acc_base = acc_clr ? '0 : r_acc;
    assign w_prod_ext = {{4{r_product[15]}}, r_product};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_state == S_DONE && r_accum) begin
            r_acc <= w_acc_base + w_prod_ext;
        end else if (acc_clr) begin
            r_acc <= '0;
        end
    end

    assign product = r_product;
    assign acc     = r_acc;

endmodule

// File: tb/tb_booth_r4_seq_mac.sv
// Directed bench for booth_r4_seq_mac: latency, products, accumulate chain,
// back-to-back starts, mid-run reset and clear/accumulate interaction.
module tb_booth_r4_seq_mac;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        accumulate;
    logic        acc_clr;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [19:0] acc;

    int total;
    int bad;

    booth_r4_seq_mac u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .accumulate (accumulate),
        .acc_clr    (acc_clr),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .acc        (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept on the next edge, scramble inputs during RUN, check latency,
    // product, and the acc value after the DONE edge.
    task automatic run_mul(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic tacc, input logic tclr,
                           input logic [15:0] exp_p, input logic [19:0] exp_acc);
        int n;
        @(negedge clk);
        a = ta;
        b = tb_v;
        accumulate = tacc;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        start = 1'b0;
        a = ~ta;
        b = 8'h5A;
        accumulate = ~tacc;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, 32'd5);
        check({tag, "_prod"}, {16'd0, product}, {16'd0, exp_p});
        if (tclr) acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        check({tag, "_acc"}, {12'd0, acc}, {12'd0, exp_acc});
        check({tag, "_done0"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int dcount;
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b1;
        a = 8'd9;
        b = 8'd9;
        accumulate = 1'b1;
        acc_clr = 1'b0;

        // start held during reset must not be acted on
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_prod", {16'd0, product}, 32'd0);
        check("rst_acc", {12'd0, acc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        run_mul("m30x27", 8'd30, 8'd27, 1'b0, 1'b0, 16'h032A, 20'h00000);
        run_mul("mneg128", 8'h80, 8'h80, 1'b0, 1'b0, 16'h4000, 20'h00000);
        run_mul("mneg1x127", 8'hFF, 8'd127, 1'b0, 1'b0, 16'hFF81, 20'h00000);
        run_mul("chain1", 8'd100, 8'd100, 1'b1, 1'b0, 16'h2710, 20'h02710);
        run_mul("chain2", 8'hCE, 8'd3, 1'b1, 1'b0, 16'hFF6A, 20'h0267A);

        // start held high: a result every 6 cycles, RUN-time operand changes ignored
        @(negedge clk);
        a = 8'd5;
        b = 8'd6;
        accumulate = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
                if (busy && n <= 2) begin
                    a = 8'h7F;
                    b = 8'h81;
                end
            end while (!done && n < 20);
            check($sformatf("hold_gap%0d", k), n, (k == 0) ? 32'd5 : 32'd6);
            check($sformatf("hold_prod%0d", k), {16'd0, product}, 32'h001E);
            a = 8'd5;
            b = 8'd6;
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_stop", {31'd0, busy}, 32'd0);
        check("hold_acc", {12'd0, acc}, 32'h0267A);

        // reset during RUN iteration 2
        @(negedge clk);
        a = 8'd11;
        b = 8'd13;
        accumulate = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_prod", {16'd0, product}, 32'd0);
        check("mid_rst_acc", {12'd0, acc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("mid_rst_nodone", dcount, 32'd0);
        check("mid_rst_acc2", {12'd0, acc}, 32'd0);
        run_mul("m3xneg4", 8'd3, 8'hFC, 1'b0, 1'b0, 16'hFFF4, 20'h00000);

        // clear and accumulate on the same DONE edge
        run_mul("preload", 8'd100, 8'd100, 1'b1, 1'b0, 16'h2710, 20'h02710);
        run_mul("clr_acc", 8'd7, 8'd1, 1'b1, 1'b1, 16'h0007, 20'h00007);

        // clear alone in IDLE
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        check("idle_clr", {12'd0, acc}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
